// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_pkg
//  Description : Shared constants for the GPIO register file: word
//                addresses, identification word defaults, width limits
//                and the byte-lane mask helper.
//  Revision    : 1.0  initial release
// ============================================================================
package gpio_pkg;

    localparam int NPINS_MAX    = 32;
    localparam int NSCRATCH_MAX = 8;

    localparam logic [31:0] CNAME_DEFAULT    = 32'h48524a44;
    localparam logic [31:0] CVERSION_DEFAULT = 32'h00000002;

    localparam logic [3:0] ADDR_CNAME      = 4'd0;
    localparam logic [3:0] ADDR_CVERSION   = 4'd1;
    localparam logic [3:0] ADDR_OE         = 4'd2;
    localparam logic [3:0] ADDR_PINSTATE   = 4'd3;
    localparam logic [3:0] ADDR_IRQ_MASK   = 4'd4;
    localparam logic [3:0] ADDR_DATA       = 4'd5;
    localparam logic [3:0] ADDR_IRQ_RISE   = 4'd6;
    localparam logic [3:0] ADDR_IRQ_FALL   = 4'd7;
    localparam logic [3:0] ADDR_IRQ_STATUS = 4'd8;
    localparam logic [3:0] ADDR_SCRATCH0   = 4'd9;

    // Expand the four byte enables into a 32-bit bit mask
    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_sync_edge
//  Description : Multi-flop synchroniser for the raw pad inputs plus a
//                one-cycle delayed copy used to flag rising/falling edges
//                of the synchronised pin state.
//  Revision    : 1.0  initial release
// ============================================================================
module gpio_sync_edge #(
    parameter int NPINS       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NPINS-1:0] pin_in,
    output logic [NPINS-1:0] pin_sync,
    output logic [NPINS-1:0] rise_raw,
    output logic [NPINS-1:0] fall_raw
);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("gpio_sync_edge: SYNC_STAGES must be at least 2");
    end

    logic [NPINS-1:0] r_sync [SYNC_STAGES];
    logic [NPINS-1:0] r_dly;

    // Synchroniser chain; stage 0 is the only flop that sees the async pad
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Delayed copy starts at 0 so a pin already high at reset release
    // is reported as a rising edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dly <= '0;
        end else begin
            r_dly <= r_sync[SYNC_STAGES-1];
        end
    end

    assign pin_sync = r_sync[SYNC_STAGES-1];
    assign rise_raw = r_sync[SYNC_STAGES-1] & ~r_dly;
    assign fall_raw = ~r_sync[SYNC_STAGES-1] & r_dly;

endmodule
`default_nettype wire

// File: rtl/gpio_regfile_irq.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_regfile_irq
//  Description : Parametrised GPIO control/status register file with
//                byte-enable writes, registered one-cycle read response,
//                synchronised pin state, banked scratch words and per-pin
//                edge interrupts (sticky W1C status, masked level irq).
//  Revision    : 1.0  initial release
// ============================================================================
module gpio_regfile_irq
    import gpio_pkg::*;
#(
    parameter int          NPINS       = 16,
    parameter int          SYNC_STAGES = 2,
    parameter int          NSCRATCH    = 2,
    parameter logic [31:0] CNAME       = CNAME_DEFAULT,
    parameter logic [31:0] CVERSION    = CVERSION_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic             r_wn,
    input  logic [5:2]       addr,
    input  logic [3:0]       wben,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             rvalid,
    input  logic [NPINS-1:0] pin_in,
    output logic [NPINS-1:0] gpio_out,
    output logic [NPINS-1:0] gpio_oe,
    output logic             irq
);

    if (NPINS < 1 || NPINS > NPINS_MAX) begin : g_bad_npins
        $error("gpio_regfile_irq: NPINS must be in 1..32");
    end
    if (NSCRATCH < 1 || NSCRATCH > NSCRATCH_MAX) begin : g_bad_nscratch
        $error("gpio_regfile_irq: NSCRATCH must be in 1..8");
    end

    // Byte-lane merge for the pin-wide registers
    function automatic logic [NPINS-1:0] f_merge(
        input logic [NPINS-1:0] old_v,
        input logic [NPINS-1:0] new_v,
        input logic [NPINS-1:0] mask
    );
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    logic             w_wr;
    logic             w_rd;
    logic [31:0]      w_bmask32;
    logic [NPINS-1:0] w_bmask;
    logic [NPINS-1:0] w_wdat;

    logic [NPINS-1:0] r_oe;
    logic [NPINS-1:0] r_data;
    logic [NPINS-1:0] r_mask;
    logic [NPINS-1:0] r_rise;
    logic [NPINS-1:0] r_fall;
    logic [NPINS-1:0] r_status;
    logic             r_irq;
    logic [31:0]      r_rdata;
    logic             r_rvalid;

    logic [NPINS-1:0] w_pin_sync;
    logic [NPINS-1:0] w_rise_raw;
    logic [NPINS-1:0] w_fall_raw;
    logic [NPINS-1:0] w_set;
    logic [NPINS-1:0] w_clr;
    logic [31:0]      w_rword;
    logic [31:0]      w_scr [NSCRATCH];

    assign w_wr      = sel & ~r_wn;
    assign w_rd      = sel & r_wn;
    assign w_bmask32 = byte_mask(wben);
    assign w_bmask   = w_bmask32[NPINS-1:0];
    assign w_wdat    = wdata[NPINS-1:0];

    gpio_sync_edge #(
        .NPINS       (NPINS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .reset    (reset),
        .pin_in   (pin_in),
        .pin_sync (w_pin_sync),
        .rise_raw (w_rise_raw),
        .fall_raw (w_fall_raw)
    );

    // Control registers: byte-lane merge on a write to the matching word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_oe   <= '0;
            r_data <= '0;
            r_mask <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else if (w_wr) begin
            case (addr)
                ADDR_OE:       r_oe   <= f_merge(r_oe,   w_wdat, w_bmask);
                ADDR_IRQ_MASK: r_mask <= f_merge(r_mask, w_wdat, w_bmask);
                ADDR_DATA:     r_data <= f_merge(r_data, w_wdat, w_bmask);
                ADDR_IRQ_RISE: r_rise <= f_merge(r_rise, w_wdat, w_bmask);
                ADDR_IRQ_FALL: r_fall <= f_merge(r_fall, w_wdat, w_bmask);
                default:       ;
            endcase
        end
    end

    // Scratch words, one register per bank entry; addresses beyond 15
    // cannot be reached by the 4-bit word address and are simply inert
    for (genvar g = 0; g < NSCRATCH; g++) begin : g_scratch
        logic [31:0] r_word;
        logic        w_hit;

        assign w_hit = ({1'b0, addr} == (5'(ADDR_SCRATCH0) + 5'(g)));

        // Full 32-bit byte-lane merge on a write to this entry
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_word <= '0;
            end else if (w_wr && w_hit) begin
                r_word <= (r_word & ~w_bmask32) | (wdata & w_bmask32);
            end
        end

        assign w_scr[g] = r_word;
    end

    // Enabled edges set status; W1C clears only bits selected by wben
    always_comb begin
        w_set = (w_rise_raw & r_rise) | (w_fall_raw & r_fall);
        w_clr = '0;
        if (w_wr && (addr == ADDR_IRQ_STATUS)) begin
            w_clr = w_wdat & w_bmask;
        end
    end

    // Sticky status: a new event in the same cycle as its clear survives
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_status <= '0;
        end else begin
            r_status <= (r_status & ~w_clr) | w_set;
        end
    end

    // Registered interrupt level, gated by the mask only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_status & r_mask);
        end
    end

    // Read mux; narrow registers are zero-extended to 32 bits
    always_comb begin
        w_rword = '0;
        case (addr)
            ADDR_CNAME:      w_rword              = CNAME;
            ADDR_CVERSION:   w_rword              = CVERSION;
            ADDR_OE:         w_rword[NPINS-1:0]   = r_oe;
            ADDR_PINSTATE:   w_rword[NPINS-1:0]   = w_pin_sync;
            ADDR_IRQ_MASK:   w_rword[NPINS-1:0]   = r_mask;
            ADDR_DATA:       w_rword[NPINS-1:0]   = r_data;
            ADDR_IRQ_RISE:   w_rword[NPINS-1:0]   = r_rise;
            ADDR_IRQ_FALL:   w_rword[NPINS-1:0]   = r_fall;
            ADDR_IRQ_STATUS: w_rword[NPINS-1:0]   = r_status;
            default: begin
                for (int k = 0; k < NSCRATCH; k++) begin
                    if ({1'b0, addr} == (5'(ADDR_SCRATCH0) + 5'(k))) begin
                        w_rword = w_scr[k];
                    end
                end
            end
        endcase
    end

    // Read response: rdata captured per read and held; rvalid is a pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rword;
            end
        end
    end

    assign rdata    = r_rdata;
    assign rvalid   = r_rvalid;
    assign gpio_out = r_data;
    assign gpio_oe  = r_oe;
    assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_gpio_regfile_irq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_regfile_irq
//  Description : Self-checking bench for gpio_regfile_irq. Three instances
//                (8, 16 and 32 pins) share one bus; a behavioural model
//                queues expected read data and a monitor per instance
//                compares every response and output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gpio_regfile_irq;

    localparam int SYNC  = 2;
    localparam int NSCR  = 2;
    localparam int NINST = 3;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        sel   = 1'b0;
    logic        r_wn  = 1'b0;
    logic [3:0]  addr  = '0;
    logic [3:0]  wben  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] pin_bus = '0;

    logic [31:0] rdata_w  [NINST];
    logic        rvalid_w [NINST];
    logic        irq_w    [NINST];
    logic [31:0] gout_w   [NINST];
    logic [31:0] goe_w    [NINST];

    int errors = 0;
    int checks = 0;

    // Reference model state (values held zero-extended to 32 bits)
    logic [31:0] wm     [NINST];
    logic [31:0] m_oe   [NINST];
    logic [31:0] m_data [NINST];
    logic [31:0] m_mask [NINST];
    logic [31:0] m_rise [NINST];
    logic [31:0] m_fall [NINST];
    logic [31:0] m_st   [NINST];
    logic [31:0] m_scr  [NINST][NSCR];
    logic [31:0] m_hist [NINST][SYNC+1];
    logic        m_irq    [NINST];
    logic        m_rvalid [NINST];
    logic [31:0] exp_q [NINST][$];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_oe[k] = '0; m_data[k] = '0; m_mask[k] = '0;
        m_rise[k] = '0; m_fall[k] = '0; m_st[k] = '0;
        m_irq[k] = 1'b0; m_rvalid[k] = 1'b0;
        for (int j = 0; j < NSCR; j++) m_scr[k][j] = '0;
        for (int j = 0; j <= SYNC; j++) m_hist[k][j] = '0;
        exp_q[k].delete();
    endtask

    // Advance the model by one clock edge using the inputs now on the bus
    task automatic model_update();
        logic [31:0] bm, m, s, d, set_v, clr_v, rv;
        int a;
        bm = {{8{wben[3]}}, {8{wben[2]}}, {8{wben[1]}}, {8{wben[0]}}};
        a  = int'(addr);
        for (int k = 0; k < NINST; k++) begin
            if (!reset) begin
                model_reset(k);
            end else begin
                m = bm & wm[k];
                s = m_hist[k][SYNC-1];   // synchronised pin state
                d = m_hist[k][SYNC];     // same, one cycle older
                m_rvalid[k] = sel && r_wn;
                if (sel && r_wn) begin
                    case (a)
                        0: rv = 32'h48524a44;
                        1: rv = 32'h00000002;
                        2: rv = m_oe[k];
                        3: rv = s;
                        4: rv = m_mask[k];
                        5: rv = m_data[k];
                        6: rv = m_rise[k];
                        7: rv = m_fall[k];
                        8: rv = m_st[k];
                        default: rv = (a >= 9 && a < 9 + NSCR) ? m_scr[k][a-9] : 32'h0;
                    endcase
                    exp_q[k].push_back(rv);
                end
                set_v = (s & ~d & m_rise[k]) | (~s & d & m_fall[k]);
                clr_v = (sel && !r_wn && a == 8) ? (wdata & m) : 32'h0;
                m_irq[k] = |(m_st[k] & m_mask[k]);
                if (sel && !r_wn) begin
                    case (a)
                        2: m_oe[k]   = (m_oe[k]   & ~m) | (wdata & m);
                        4: m_mask[k] = (m_mask[k] & ~m) | (wdata & m);
                        5: m_data[k] = (m_data[k] & ~m) | (wdata & m);
                        6: m_rise[k] = (m_rise[k] & ~m) | (wdata & m);
                        7: m_fall[k] = (m_fall[k] & ~m) | (wdata & m);
                        default: begin
                            if (a >= 9 && a < 9 + NSCR)
                                m_scr[k][a-9] = (m_scr[k][a-9] & ~bm) | (wdata & bm);
                        end
                    endcase
                end
                m_st[k] = (m_st[k] & ~clr_v) | set_v;
                for (int j = SYNC; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
                m_hist[k][0] = pin_bus & wm[k];
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        sel = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        sel = 1'b1; r_wn = 1'b0; addr = a; wben = be; wdata = d;
        tick();
        sel = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        sel = 1'b1; r_wn = 1'b1; addr = a;
        tick();
        sel = 1'b0;
    endtask

    for (genvar gi = 0; gi < NINST; gi++) begin : g_dut
        localparam int NP = (gi == 0) ? 8 : ((gi == 1) ? 16 : 32);
        logic [NP-1:0] go;
        logic [NP-1:0] oe;

        gpio_regfile_irq #(
            .NPINS       (NP),
            .SYNC_STAGES (SYNC),
            .NSCRATCH    (NSCR)
        ) dut (
            .clk      (clk),
            .reset    (reset),
            .sel      (sel),
            .r_wn     (r_wn),
            .addr     (addr),
            .wben     (wben),
            .wdata    (wdata),
            .rdata    (rdata_w[gi]),
            .rvalid   (rvalid_w[gi]),
            .pin_in   (pin_bus[NP-1:0]),
            .gpio_out (go),
            .gpio_oe  (oe),
            .irq      (irq_w[gi])
        );

        assign gout_w[gi] = 32'(go);
        assign goe_w[gi]  = 32'(oe);

        // Monitor: pops the scoreboard on each rvalid, tracks outputs
        initial forever begin
            @(posedge clk);
            #1;
            check($sformatf("np%0d rvalid", NP), 32'(rvalid_w[gi]), 32'(m_rvalid[gi]));
            if (rvalid_w[gi]) begin
                if (exp_q[gi].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL np%0d rdata: got %h with no read outstanding", NP, rdata_w[gi]);
                end else begin
                    check($sformatf("np%0d rdata", NP), rdata_w[gi], exp_q[gi].pop_front());
                end
            end
            check($sformatf("np%0d irq", NP), 32'(irq_w[gi]), 32'(m_irq[gi]));
            check($sformatf("np%0d gpio_out", NP), gout_w[gi], m_data[gi]);
            check($sformatf("np%0d gpio_oe", NP), goe_w[gi], m_oe[gi]);
        end
    end

    initial begin
        int n;
        wm[0] = 32'h000000FF;
        wm[1] = 32'h0000FFFF;
        wm[2] = 32'hFFFFFFFF;
        for (int k = 0; k < NINST; k++) model_reset(k);
        repeat (3) tick();
        reset = 1'b1;

        // Some state, then reset asserted in the middle of a write
        wr(4'd5, 4'hF, 32'h12345678);
        wr(4'd2, 4'hF, 32'hFFFFFFFF);
        rd(4'd0);
        sel = 1'b1; r_wn = 1'b0; addr = 4'd5; wben = 4'hF; wdata = 32'hFFFFFFFF;
        #2 reset = 1'b0;
        for (int k = 0; k < NINST; k++) model_reset(k);
        #1;
        for (int k = 0; k < NINST; k++) begin
            check($sformatf("reset gpio_out %0d", k), gout_w[k], 32'h0);
            check($sformatf("reset gpio_oe %0d", k), goe_w[k], 32'h0);
            check($sformatf("reset irq %0d", k), 32'(irq_w[k]), 32'h0);
            check($sformatf("reset rvalid %0d", k), 32'(rvalid_w[k]), 32'h0);
            check($sformatf("reset rdata %0d", k), rdata_w[k], 32'h0);
        end
        tick();
        sel = 1'b0;
        tick();
        reset = 1'b1;
        rd(4'd0);
        check("cname read", rdata_w[1], 32'h48524a44);
        check("cname rvalid", 32'(rvalid_w[1]), 32'h1);
        idle();
        check("rvalid pulse", 32'(rvalid_w[1]), 32'h0);
        check("rdata hold", rdata_w[1], 32'h48524a44);

        // Byte enables on DATA
        wr(4'd5, 4'b0001, 32'h0000A5C3);
        check("data be0 np16", gout_w[1], 32'h000000C3);
        check("data be0 np8", gout_w[0], 32'h000000C3);
        wr(4'd5, 4'b0011, 32'h0000A5C3);
        check("data be01 np16", gout_w[1], 32'h0000A5C3);
        check("data be01 np8", gout_w[0], 32'h000000C3);
        check("data be01 np32", gout_w[2], 32'h0000A5C3);

        // Byte enables on scratch
        wr(4'd9, 4'b1100, 32'hDEADBEEF);
        rd(4'd9);
        for (int k = 0; k < NINST; k++)
            check($sformatf("scratch be23 %0d", k), rdata_w[k], 32'hDEAD0000);

        // Synchroniser latency, no interrupt enabled
        pin_bus[3] = 1'b1;
        n = 0;
        do begin
            rd(4'd3);
            n++;
        end while (!rdata_w[1][3] && n < 10);
        check("sync latency", 32'(n), 32'(SYNC + 1));
        idle();
        idle();
        rd(4'd8);
        check("no-irq status", rdata_w[1], 32'h0);
        check("no-irq irq", 32'(irq_w[1]), 32'h0);

        // Rise interrupt on pin 3
        pin_bus[3] = 1'b0;
        repeat (5) idle();
        wr(4'd6, 4'hF, 32'h00000008);
        wr(4'd4, 4'hF, 32'h00000008);
        pin_bus[3] = 1'b1;
        n = 0;
        while (!irq_w[1] && n < 10) begin
            idle();
            n++;
        end
        check("irq latency", 32'(n), 32'(SYNC + 2));
        rd(4'd8);
        for (int k = 0; k < NINST; k++)
            check($sformatf("rise status %0d", k), rdata_w[k], 32'h00000008);

        // W1C and its one-cycle irq release
        wr(4'd8, 4'hF, 32'h00000008);
        check("irq still set at clear", 32'(irq_w[1]), 32'h1);
        idle();
        check("irq after w1c", 32'(irq_w[1]), 32'h0);

        // W1C on the same edge as a new rise event: set wins
        pin_bus[3] = 1'b0;
        repeat (5) idle();
        pin_bus[3] = 1'b1;
        repeat (SYNC) idle();
        wr(4'd8, 4'hF, 32'h00000008);
        rd(4'd8);
        check("set beats clear", rdata_w[1], 32'h00000008);
        wr(4'd8, 4'hF, 32'hFFFFFFFF);
        repeat (2) idle();

        // Mask gating with a falling edge on pin 5
        wr(4'd4, 4'hF, 32'h0);
        wr(4'd7, 4'hF, 32'h00000020);
        pin_bus[5] = 1'b1;
        repeat (5) idle();
        pin_bus[5] = 1'b0;
        repeat (5) idle();
        rd(4'd8);
        for (int k = 0; k < NINST; k++)
            check($sformatf("fall status %0d", k), rdata_w[k], 32'h00000020);
        check("masked irq", 32'(irq_w[1]), 32'h0);
        wr(4'd4, 4'hF, 32'h00000020);
        check("mask edge irq", 32'(irq_w[1]), 32'h0);
        idle();
        check("unmasked irq", 32'(irq_w[1]), 32'h1);
        wr(4'd8, 4'hF, 32'h00000020);
        repeat (2) idle();

        // Unmapped read and read-only write
        rd(4'd15);
        check("unmapped rdata", rdata_w[1], 32'h0);
        check("unmapped rvalid", 32'(rvalid_w[1]), 32'h1);
        wr(4'd1, 4'hF, 32'hFFFFFFFF);
        rd(4'd1);
        check("cversion ro", rdata_w[1], 32'h00000002);

        // Width: upper bits read 0, full width reachable
        wr(4'd2, 4'hF, 32'hFFFFFFFF);
        rd(4'd2);
        check("oe np8", rdata_w[0], 32'h000000FF);
        check("oe np16", rdata_w[1], 32'h0000FFFF);
        check("oe np32", rdata_w[2], 32'hFFFFFFFF);
        check("oe pins np32", goe_w[2], 32'hFFFFFFFF);
        pin_bus[31] = 1'b1;
        repeat (4) idle();
        rd(4'd3);
        check("pin31 np32", rdata_w[2], 32'h80000008);
        check("pin31 np8", rdata_w[0], 32'h00000008);

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                #3 reset = 1'b0;
                for (int k = 0; k < NINST; k++) model_reset(k);
                sel = 1'b0;
                tick();
                reset = 1'b1;
            end
            if ($urandom_range(0, 5) == 0)
                pin_bus = pin_bus ^ (32'h1 << $urandom_range(0, 31));
            sel   = ($urandom_range(0, 2) != 0);
            r_wn  = 1'($urandom_range(0, 1));
            addr  = 4'($urandom_range(0, 15));
            wben  = 4'($urandom_range(0, 15));
            wdata = $urandom;
            tick();
        end
        sel = 1'b0;
        repeat (3) idle();
        for (int k = 0; k < NINST; k++)
            check($sformatf("scoreboard drained %0d", k), 32'(exp_q[k].size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
